// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader state encoding and region constants
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } upg_state_t;

    localparam int REG_IMEM            = 0;
    localparam int REG_DMEM            = 1;
    localparam int DEFAULT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/upg_word_assembler.sv
// rtl/upg_word_assembler.sv - packs a byte stream into little-endian words
module upg_word_assembler import cpu_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word,
    output logic              partial
);

    localparam int N_BYTES = DATA_W / 8;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    logic [IDX_W-1:0] byte_idx;

    // Lanes are written in place, so the word is complete the cycle after its last byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                word[{byte_idx, 3'b000} +: 8] <= byte_data;
                if (byte_idx == LAST_IDX) begin
                    byte_idx   <= '0;
                    word_valid <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

    assign partial = (byte_idx != '0);

endmodule

// File: rtl/upg_loader.sv
// rtl/upg_loader.sv - UART image loader streaming words into memory regions
module upg_loader import cpu_pkg::*; #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int N_REGIONS   = 2,
    parameter int RSEL_W      = 1,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     upg_wen_o,
    output logic [RSEL_W+ADDR_W-1:0] upg_adr_o,
    output logic [DATA_W-1:0]        upg_dat_o,
    output logic                     upg_done_o,
    output logic                     upg_err_o,
    output logic                     busy_o,
    output logic                     cpu_rst_o,
    output logic [RSEL_W+ADDR_W:0]   word_cnt_o
);

    localparam int CW   = RSEL_W + ADDR_W + 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = '1;
    localparam logic [RSEL_W-1:0] REGION_LAST = RSEL_W'(N_REGIONS - 1);

    upg_state_t        state, state_nxt;
    logic              start_q, start_edge, in_load, byte_acc;
    logic              word_valid, partial, last_word, timeout, got_byte;
    logic [DATA_W-1:0] word;
    logic [RSEL_W-1:0] region;
    logic [ADDR_W-1:0] word_addr;
    logic [CW-1:0]     word_cnt;
    logic [TO_W-1:0]   to_cnt;

    assign start_edge = start_i && !start_q;
    assign in_load    = (state == ST_LOAD);
    assign byte_acc   = rx_valid_i && in_load && !start_edge;
    assign last_word  = word_valid && (word_addr == ADDR_LAST) && (region == REGION_LAST);
    assign timeout    = in_load && got_byte && !byte_acc && (to_cnt == TO_LAST);

    upg_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_edge),
        .byte_valid (byte_acc),
        .byte_data  (rx_data_i),
        .word_valid (word_valid),
        .word       (word),
        .partial    (partial)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start_i;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_edge) begin
            state_nxt = ST_LOAD;
        end else if (in_load) begin
            if (last_word) begin
                state_nxt = ST_DONE;
            end else if (timeout) begin
                state_nxt = partial ? ST_ERR : ST_DONE;
            end
        end
    end

    // Idle counting only starts once the first byte has arrived
    always_ff @(posedge clk) begin
        if (!rst_n || start_edge) begin
            region    <= '0;
            word_addr <= '0;
            word_cnt  <= '0;
            to_cnt    <= '0;
            got_byte  <= 1'b0;
        end else if (in_load) begin
            if (word_valid) begin
                word_cnt <= word_cnt + CW'(1);
                if (word_addr == ADDR_LAST) begin
                    word_addr <= '0;
                    if (region != REGION_LAST) begin
                        region <= region + RSEL_W'(1);
                    end
                end else begin
                    word_addr <= word_addr + ADDR_W'(1);
                end
            end
            if (byte_acc) begin
                to_cnt   <= '0;
                got_byte <= 1'b1;
            end else if (got_byte && to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign upg_wen_o  = word_valid && in_load;
    assign upg_adr_o  = {region, word_addr};
    assign upg_dat_o  = word;
    assign upg_done_o = (state == ST_DONE);
    assign upg_err_o  = (state == ST_ERR);
    assign busy_o     = in_load;
    assign cpu_rst_o  = in_load;
    assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_upg_loader.sv
// tb/tb_upg_loader.sv - self-checking bench for upg_loader
module tb_upg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        upg_wen_o;
    logic [2:0]  upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o, upg_err_o, busy_o, cpu_rst_o;
    logic [3:0]  word_cnt_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  img[$];
    logic [2:0]  wadr_q[$];
    logic [31:0] wdat_q[$];
    int          wcyc_q[$];

    typedef struct {
        int   n;
        logic done;
        logic err;
        logic busy;
        int   cnt;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] pat8[8];

    upg_loader #(
        .DATA_W(32), .ADDR_W(2), .N_REGIONS(2), .RSEL_W(1), .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .upg_err_o  (upg_err_o),
        .busy_o     (busy_o),
        .cpu_rst_o  (cpu_rst_o),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && upg_wen_o) begin
            wadr_q.push_back(upg_adr_o);
            wdat_q.push_back(upg_dat_o);
            wcyc_q.push_back(cyc);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        img.delete();
        wadr_q.delete();
        wdat_q.delete();
        wcyc_q.delete();
    endtask

    task automatic do_start();
        clear_obs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        img.push_back(b);
        tick();
        rx_valid_i = 1'b0;
    endtask

    // Reference: the n accepted bytes form min(n/4, 8) words at consecutive addresses
    task automatic check_image(string tag, logic ed, logic ee, logic eb, int ec);
        int nw;
        logic [31:0] exp_dat;
        nw = img.size() / 4;
        if (nw > 8) nw = 8;
        chk({tag, " n_writes"}, wdat_q.size(), nw);
        for (int k = 0; k < nw && k < wdat_q.size(); k++) begin
            exp_dat = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
            chk($sformatf("%s adr%0d", tag, k), wadr_q[k], k);
            chk($sformatf("%s dat%0d", tag, k), wdat_q[k], exp_dat);
        end
        chk({tag, " done"}, upg_done_o, ed);
        chk({tag, " err"}, upg_err_o, ee);
        chk({tag, " busy"}, busy_o, eb);
        chk({tag, " cpu_rst"}, cpu_rst_o, eb);
        chk({tag, " word_cnt"}, word_cnt_o, ec);
    endtask

    initial begin
        int n, nw, last_cyc;
        logic mdone, merr;

        tbl[0] = '{n: 32, done: 1, err: 0, busy: 0, cnt: 8};
        tbl[1] = '{n: 8,  done: 1, err: 0, busy: 0, cnt: 2};
        tbl[2] = '{n: 6,  done: 0, err: 1, busy: 0, cnt: 1};
        tbl[3] = '{n: 1,  done: 0, err: 1, busy: 0, cnt: 0};
        tbl[4] = '{n: 4,  done: 1, err: 0, busy: 0, cnt: 1};
        tbl[5] = '{n: 0,  done: 0, err: 0, busy: 1, cnt: 0};
        tbl[6] = '{n: 35, done: 1, err: 0, busy: 0, cnt: 8};
        tbl[7] = '{n: 13, done: 0, err: 1, busy: 0, cnt: 3};
        pat8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset and idle
        idle(3);
        chk("rst wen", upg_wen_o, 0);
        chk("rst adr", upg_adr_o, 0);
        chk("rst dat", upg_dat_o, 0);
        chk("rst done", upg_done_o, 0);
        chk("rst err", upg_err_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst cpu_rst", cpu_rst_o, 0);
        chk("rst cnt", word_cnt_o, 0);
        rst_n = 1'b1;
        tick();
        clear_obs();
        for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h50));
        idle(20);
        chk("prestart writes", wdat_q.size(), 0);
        chk("prestart cnt", word_cnt_o, 0);
        chk("prestart busy", busy_o, 0);
        chk("prestart done", upg_done_o, 0);

        // Table-driven images
        for (int e = 0; e < 8; e++) begin
            do_start();
            chk($sformatf("vec%0d busy_after_start", e), busy_o, 1);
            for (int i = 0; i < tbl[e].n; i++) begin
                if (e == 0) send_byte(8'(i));
                else if (e == 1) send_byte(pat8[i]);
                else send_byte(8'($urandom));
            end
            idle(20);
            check_image($sformatf("vec%0d", e), tbl[e].done, tbl[e].err, tbl[e].busy, tbl[e].cnt);
            if (e == 0) begin
                chk("full first adr", wadr_q[0], 3'b000);
                chk("full first dat", wdat_q[0], 32'h03020100);
                chk("full fifth adr", wadr_q[4], 3'b100);
                chk("full fifth dat", wdat_q[4], 32'h13121110);
            end
            if (e == 1) begin
                chk("short w0", wdat_q[0], 32'hDDCCBBAA);
                chk("short w1", wdat_q[1], 32'h44332211);
            end
        end

        // Restart mid-word discards the partial word
        do_start();
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        do_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        idle(20);
        chk("restart n_writes", wdat_q.size(), 1);
        chk("restart dat", wdat_q[0], 32'h04030201);
        chk("restart adr", wadr_q[0], 0);
        chk("restart cnt", word_cnt_o, 1);
        chk("restart done", upg_done_o, 1);

        // Start edge together with a byte: the byte is dropped
        clear_obs();
        start_i    = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hEE;
        tick();
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
        idle(20);
        check_image("start_vs_byte", 1, 0, 0, 1);
        chk("start_vs_byte dat", wdat_q[0], 32'h73727170);

        // Write-strobe latency with a byte arriving in the write cycle
        do_start();
        for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i));
        send_byte(8'h93);
        last_cyc = cyc;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        idle(20);
        chk("latency", wcyc_q[0], last_cyc);
        chk("latency next dat", wdat_q[1], 32'hA3A2A1A0);
        check_image("latency", 1, 0, 0, 2);

        // Randomised images with random inter-byte gaps below the timeout
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 40);
            do_start();
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom));
                idle($urandom_range(0, 12));
            end
            idle(20);
            nw    = (n / 4 > 8) ? 8 : n / 4;
            mdone = (n >= 32) || (n > 0 && n % 4 == 0);
            merr  = (n > 0) && (n < 32) && (n % 4 != 0);
            check_image($sformatf("rand%0d n=%0d", r, n), mdone, merr, n == 0, nw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
